// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86-64 fetch definitions: opcode and status codes,
//                fetch state encoding and the opcode-to-length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] len;
    } len_info_t;

    // Instruction length in bytes by opcode; unknown opcodes report invalid.
    function automatic len_info_t instr_len(input logic [3:0] icode);
        len_info_t r;
        r.valid = 1'b1;
        case (icode)
            I_HALT, I_NOP, I_RET:              r.len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  r.len = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      r.len = 4'd10;
            I_JXX, I_CALL:                     r.len = 4'd9;
            default: begin
                r.valid = 1'b0;
                r.len   = 4'd1;
            end
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_len_decode.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_len_decode
//  Description : Combinational opcode-byte decode: instruction length,
//                register-byte / constant presence and illegal-opcode flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    input  logic [3:0] ifun_i,
    output logic [3:0] len_o,
    output logic       has_regids_o,
    output logic       has_valc_o,
    output logic       ins_err_o
);

    len_info_t w_info;

    // Illegal opcodes collapse to a one-byte instruction with no operands.
    always_comb begin
        w_info    = instr_len(icode_i);
        ins_err_o = !w_info.valid;
        case (icode_i)
            I_OPQ:          if (ifun_i > 4'd3) ins_err_o = 1'b1;
            I_JXX, I_RRMOVQ: if (ifun_i > 4'd6) ins_err_o = 1'b1;
            default: ;
        endcase
        len_o        = ins_err_o ? 4'd1 : w_info.len;
        has_regids_o = !ins_err_o && (icode_i inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ,
                                                      I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ});
        has_valc_o   = !ins_err_o && (icode_i inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                                      I_JXX, I_CALL});
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Multi-cycle Y86-64 fetch controller. Reads instruction bytes
//                one at a time, assembles a decoded bundle and hands it to
//                decode over valid/ready. Optional performance counters are
//                enabled with the FETCH_PERF_CNT_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import y86_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int IMEM_SIZE = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_rvalid,
    input  logic [7:0]      mem_rdata,
    input  logic            mem_err,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [3:0]      icode,
    output logic [3:0]      ifun,
    output logic [3:0]      rA,
    output logic [3:0]      rB,
    output logic [63:0]     valC,
    output logic [PC_W-1:0] valP,
    output logic [PC_W-1:0] pc_out,
    output logic [2:0]      stat,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     instr_count,
    output logic [31:0]     stall_count,
`endif
    output logic            busy
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      k_q, k_d;
    logic [3:0]      len_q, len_d;
    logic [9:0][7:0] buf_q, buf_d;
    logic [2:0]      stat_q, stat_d;
    logic            hasreg_q, hasreg_d;
    logic            hasvalc_q, hasvalc_d;
    logic            discard_q, discard_d;

    logic [3:0]      w_dec_len;
    logic            w_dec_regids, w_dec_valc, w_dec_ins;
    logic [PC_W:0]   w_addr_ext;
    logic            w_addr_err, w_issue, w_resp, w_redir, w_clear;
    logic [3:0]      w_len_eff;
    logic [PC_W-1:0] w_valp;

    fetch_len_decode u_len_decode (
        .icode_i      (mem_rdata[7:4]),
        .ifun_i       (mem_rdata[3:0]),
        .len_o        (w_dec_len),
        .has_regids_o (w_dec_regids),
        .has_valc_o   (w_dec_valc),
        .ins_err_o    (w_dec_ins)
    );

    // The bounds check uses one extra bit so pc+k cannot wrap below IMEM_SIZE.
    assign w_addr_ext = {1'b0, pc_q} + (PC_W+1)'(k_q);
    assign w_addr_err = (w_addr_ext >= (PC_W+1)'(IMEM_SIZE));
    assign w_issue    = (state_q == ST_REQ) && !discard_q && !w_addr_err;
    assign w_resp     = (state_q == ST_WAIT) && mem_rvalid && !discard_q;
    assign w_redir    = redirect_valid &&
                        (state_q inside {ST_REQ, ST_WAIT, ST_HOLD});
    assign w_len_eff  = (k_q == 4'd0) ? w_dec_len : len_q;
    assign w_valp     = pc_q + PC_W'(len_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a redirect always restarts at REQ, even on a handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALTED: if (start) state_d = ST_REQ;
            ST_REQ: begin
                if (w_redir)          state_d = ST_REQ;
                else if (w_addr_err)  state_d = ST_HOLD;
                else if (w_issue)     state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_redir)                          state_d = ST_REQ;
                else if (w_resp) begin
                    if (mem_err)                      state_d = ST_HOLD;
                    else if (4'(k_q + 4'd1) < w_len_eff) state_d = ST_REQ;
                    else                              state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_redir)          state_d = ST_REQ;
                else if (instr_ready) state_d = (stat_q == S_AOK) ? ST_REQ : ST_HALTED;
            end
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: byte capture, status, PC advance and discard flag.
    always_comb begin
        pc_d      = pc_q;
        k_d       = k_q;
        len_d     = len_q;
        buf_d     = buf_q;
        stat_d    = stat_q;
        hasreg_d  = hasreg_q;
        hasvalc_d = hasvalc_q;
        w_clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: if (start) begin
                pc_d    = start_pc;
                w_clear = 1'b1;
            end
            ST_REQ, ST_WAIT, ST_HOLD: begin
                if (w_redir) begin
                    pc_d    = redirect_pc;
                    w_clear = 1'b1;
                end else if (state_q == ST_REQ) begin
                    if (w_addr_err) stat_d = S_ADR;
                end else if (state_q == ST_WAIT) begin
                    if (w_resp) begin
                        if (mem_err) begin
                            stat_d = S_ADR;
                        end else begin
                            buf_d[k_q] = mem_rdata;
                            k_d        = k_q + 4'd1;
                            if (k_q == 4'd0) begin
                                len_d     = w_dec_len;
                                hasreg_d  = w_dec_regids;
                                hasvalc_d = w_dec_valc;
                                if (w_dec_ins)                        stat_d = S_INS;
                                else if (mem_rdata[7:4] == I_HALT)    stat_d = S_HLT;
                                else                                  stat_d = S_AOK;
                            end
                        end
                    end
                end else if (instr_ready && stat_q == S_AOK) begin
                    pc_d    = w_valp;
                    w_clear = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_clear) begin
            k_d       = 4'd0;
            len_d     = 4'd0;
            buf_d     = '0;
            stat_d    = S_AOK;
            hasreg_d  = 1'b0;
            hasvalc_d = 1'b0;
        end
        // Any response clears the flag; a redirect with a request in flight sets it.
        discard_d = mem_rvalid ? 1'b0 : discard_q;
        if (w_redir && (((state_q == ST_WAIT) && !mem_rvalid) || w_issue))
            discard_d = 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            k_q       <= 4'd0;
            len_q     <= 4'd0;
            buf_q     <= '0;
            stat_q    <= S_AOK;
            hasreg_q  <= 1'b0;
            hasvalc_q <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            k_q       <= k_d;
            len_q     <= len_d;
            buf_q     <= buf_d;
            stat_q    <= stat_d;
            hasreg_q  <= hasreg_d;
            hasvalc_q <= hasvalc_d;
            discard_q <= discard_d;
        end
    end

    // Outputs: memory request and the bundle fields read from the byte buffer.
    always_comb begin
        mem_req     = w_issue;
        mem_addr    = w_issue ? (pc_q + PC_W'(k_q)) : '0;
        instr_valid = (state_q == ST_HOLD);
        busy        = !(state_q inside {ST_IDLE, ST_HALTED});
        icode       = buf_q[0][7:4];
        ifun        = buf_q[0][3:0];
        rA          = hasreg_q ? buf_q[1][7:4] : RNONE;
        rB          = hasreg_q ? buf_q[1][3:0] : RNONE;
        valC        = '0;
        if (hasvalc_q) valC = hasreg_q ? buf_q[9:2] : buf_q[8:1];
        valP        = w_valp;
        pc_out      = pc_q;
        stat        = stat_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_count_q, stall_count_q;

    // Accepted-bundle and decode-stall counters, cleared by reset and start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else if (start && (state_q inside {ST_IDLE, ST_HALTED})) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else if (state_q == ST_HOLD) begin
            if (instr_ready) instr_count_q <= instr_count_q + 32'd1;
            else             stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign instr_count = instr_count_q;
    assign stall_count = stall_count_q;
`else
    // Counters not built: no extra ports or state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer with a byte memory
//                responder, a program-level reference model and a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int IMEM = 4096;

    logic        clk, rst_n, start, redirect_valid, mem_req, mem_rvalid, mem_err;
    logic        instr_valid, instr_ready, busy;
    logic [31:0] start_pc, redirect_pc, mem_addr, valP, pc_out;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic [2:0]  stat;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_count, stall_count;
`endif

    fetch_sequencer #(.PC_W(32), .IMEM_SIZE(IMEM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .pc_out(pc_out), .stat(stat),
`ifdef FETCH_PERF_CNT_EN
        .instr_count(instr_count), .stall_count(stall_count),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc;
        logic [31:0] valp, pc;
        logic [2:0]  stat;
    } bundle_t;

    logic [7:0] mem_arr [0:IMEM-1];
    bundle_t    sb[$];
    int checks = 0, errors = 0;
    int err_addr = -1, fixed_lat = -1, req_count = 0, bad_req = 0;
    int ready_mode = 0, stall_left = 0, stall_obs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            4'h7, 4'h8:             return 9;
            default:                return 1;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] ic, input logic [3:0] fn);
        if (ic > 4'hB) return 0;
        if (ic == 4'h6 && fn > 4'd3) return 0;
        if ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6) return 0;
        return 1;
    endfunction

    function automatic bit fetchable(input logic [31:0] a);
        return (a < IMEM) && (int'(a) != err_addr);
    endfunction

    // Walks the program from pc and queues every bundle decode should see.
    task automatic model(input logic [31:0] start_at);
        logic [31:0] pc;
        logic [7:0]  b [10];
        logic [3:0]  ic;
        int          len, guard;
        bit          done, regs, hasc;
        bundle_t     e;
        pc = start_at; done = 0; guard = 0;
        while (!done && guard < 64) begin
            guard++;
            for (int i = 0; i < 10; i++) b[i] = 8'h00;
            e.stat = 3'd1; len = 0;
            if (!fetchable(pc)) e.stat = 3'd3;
            else begin
                b[0] = mem_arr[pc];
                if (!legal(b[0][7:4], b[0][3:0])) begin e.stat = 3'd4; len = 1; end
                else begin
                    len = ilen(b[0][7:4]);
                    if (b[0][7:4] == 4'h0) e.stat = 3'd2;
                    for (int k = 1; k < len; k++) begin
                        if (!fetchable(pc + k)) begin e.stat = 3'd3; break; end
                        b[k] = mem_arr[pc + k];
                    end
                end
            end
            ic   = b[0][7:4];
            regs = (e.stat != 3'd4) && (ic inside {4'h2,4'h3,4'h4,4'h5,4'h6,4'hA,4'hB});
            hasc = (e.stat != 3'd4) && (ic inside {4'h3,4'h4,4'h5,4'h7,4'h8});
            e.icode = ic; e.ifun = b[0][3:0];
            e.ra = regs ? b[1][7:4] : 4'hF;
            e.rb = regs ? b[1][3:0] : 4'hF;
            e.valc = 64'd0;
            if (hasc) for (int i = 0; i < 8; i++) e.valc[8*i +: 8] = regs ? b[i+2] : b[i+1];
            e.pc = pc; e.valp = pc + len;
            sb.push_back(e);
            if (e.stat != 3'd1) done = 1;
            else pc = pc + len;
        end
    endtask

    // Byte memory: one request at a time, response 1..3 cycles later.
    initial begin
        logic [31:0] a;
        int lat;
        mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                a = mem_addr; req_count++;
                if (a >= IMEM) bad_req++;
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
                @(posedge clk);
                repeat (lat) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_err    = (int'(a) == err_addr);
                mem_rdata  = (a < IMEM) ? mem_arr[a] : 8'($urandom);
                @(posedge clk); #1;
                mem_rvalid = 1'b0; mem_err = 1'b0;
            end
        end
    end

    // Decode-side ready generator.
    initial begin
        instr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 1) instr_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2 && instr_valid && stall_left > 0) begin
                instr_ready = 1'b0; stall_left--;
            end else instr_ready = 1'b1;
        end
    end

    // Monitor: compare every presented bundle against the scoreboard head.
    initial begin
        bundle_t e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bundle: got pc 0x%0h, expected none", pc_out);
                end else begin
                    e = sb[0];
                    check("icode", icode, e.icode);
                    check("ifun", ifun, e.ifun);
                    check("rA", rA, e.ra);
                    check("rB", rB, e.rb);
                    check("valC", valC, e.valc);
                    check("valP", valP, e.valp);
                    check("pc_out", pc_out, e.pc);
                    check("stat", stat, e.stat);
                    if (instr_ready) void'(sb.pop_front());
                    else stall_obs++;
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] pc);
        @(posedge clk); #1;
        start_pc = pc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending bundles busy=%0b, expected 0 pending and idle",
                     name, sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_icode"}, icode, 0);
        check({tag, "_rA"}, rA, 4'hF);
        check({tag, "_rB"}, rB, 4'hF);
        check({tag, "_valC"}, valC, 0);
        check({tag, "_valP"}, valP, 0);
        check({tag, "_pc_out"}, pc_out, 0);
        check({tag, "_stat"}, stat, 1);
    endtask

    task automatic wait_req(input logic [31:0] addr, input string name);
        int n = 0;
        @(negedge clk);
        while (!(mem_req && mem_addr == addr) && n < 300) begin @(negedge clk); n++; end
        check({name, "_seen"}, (n < 300), 1);
    endtask

    task automatic gen_prog(input int base, input int n);
        int a = base;
        logic [3:0] ic, fn;
        for (int i = 0; i < n; i++) begin
            ic = 4'($urandom_range(1, 11));
            fn = 4'd0;
            if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
            if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
            mem_arr[a] = {ic, fn};
            for (int k = 1; k < ilen(ic); k++) mem_arr[a + k] = 8'($urandom);
            a += ilen(ic);
        end
        case ($urandom_range(0, 3))
            0: mem_arr[a] = 8'hD5;
            1: mem_arr[a] = 8'h64;
            2: mem_arr[a] = 8'h2F;
            default: mem_arr[a] = 8'h00;
        endcase
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, ok;
        logic [7:0] irm [10];
        irm = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int i = 0; i < IMEM; i++) mem_arr[i] = 8'($urandom);
        rst_n = 0; start = 0; start_pc = 0; redirect_valid = 0; redirect_pc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1;

        // irmovq with a constant, then halt
        for (int i = 0; i < 10; i++) mem_arr[32'h100 + i] = irm[i];
        mem_arr[32'h10A] = 8'h00;
        model(32'h100); do_start(32'h100); wait_idle("irmovq", 200);

        // nop / OPq / ret / halt with a three-cycle decode stall
        mem_arr[0] = 8'h10; mem_arr[1] = 8'h60; mem_arr[2] = 8'h23;
        mem_arr[3] = 8'h90; mem_arr[4] = 8'h00;
        rc = stall_obs; ready_mode = 2; stall_left = 3;
        model(0); do_start(0); wait_idle("stall_seq", 200);
        check("stall_cycles", stall_obs - rc, 3);
        ready_mode = 0;

        // halt: then stay quiet
        mem_arr[32'h20] = 8'h00;
        model(32'h20); do_start(32'h20); wait_idle("halt", 100);
        ok = 1;
        repeat (6) begin @(negedge clk); if (mem_req || busy) ok = 0; end
        check("halted_quiet", ok, 1);

        // illegal opcode: one request only
        mem_arr[32'h200] = 8'hC0;
        rc = req_count;
        model(32'h200); do_start(32'h200); wait_idle("ins", 100);
        check("ins_req_count", req_count - rc, 1);

        // instruction running off the end of memory
        for (int i = 0; i < 4; i++) mem_arr[32'hFFC + i] = irm[i];
        rc = req_count;
        model(32'hFFC); do_start(32'hFFC); wait_idle("adr", 200);
        check("adr_req_count", req_count - rc, 4);
        check("adr_bad_req", bad_req, 0);

        // access fault on the third byte
        for (int i = 0; i < 10; i++) mem_arr[32'h300 + i] = irm[i];
        err_addr = 32'h302;
        model(32'h300); do_start(32'h300); wait_idle("mem_err", 200);
        err_addr = -1;

        // redirect while waiting on byte 5
        for (int i = 0; i < 10; i++) mem_arr[32'h30 + i] = irm[i];
        mem_arr[32'h40] = 8'h10; mem_arr[32'h41] = 8'h00;
        fixed_lat = 3;
        do_start(32'h30);
        wait_req(32'h35, "redir_byte5");
        @(posedge clk); #1;
        model(32'h40);
        redirect_pc = 32'h40; redirect_valid = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!mem_req && n < 50) begin @(negedge clk); n++; end
            check("redir_next_addr", mem_addr, 32'h40);
        end
        fixed_lat = -1;
        wait_idle("redirect", 200);

        // random programs with random decode back-pressure
        ready_mode = 1;
        for (int p = 0; p < 8; p++) begin
            int base;
            base = $urandom_range(32'h400, 32'hE00);
            gen_prog(base, $urandom_range(3, 8));
            model(base);
            do_start(base);
            repeat (3) @(posedge clk);
            #1; start_pc = 32'h0; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            wait_idle("random", 2000);
        end
        ready_mode = 0;

        // asynchronous reset while waiting on a byte
        for (int i = 0; i < 10; i++) mem_arr[32'h500 + i] = irm[i];
        fixed_lat = 2;
        do_start(32'h500);
        wait_req(32'h501, "rst_wait");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1;
        repeat (6) begin @(negedge clk); if (busy || instr_valid || mem_req) ok = 0; end
        check("post_rst_idle", ok, 1);
        fixed_lat = -1;
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle Y86-64 fetch controller that sequences instruction fetch from a byte-wide instruction-memory port.
- Reads the opcode byte, derives the instruction length from icode, and gathers the remaining bytes into a 10-byte buffer.
- Presents one decoded-field instruction per valid/ready handshake to decode, computes valP, and advances the PC.
- Sits between instruction memory and decode; accepts PC redirects from execute/writeback.

Parameters:
- PC_W, 32, width of PC, valP and memory address.
- IMEM_SIZE, 4096, instruction memory size in bytes; any byte address >= IMEM_SIZE is an address error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse in IDLE/HALTED; loads start_pc and begins fetching.
- start_pc  in  PC_W  initial PC.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  PC_W  new PC.
- mem_req  out  1  byte read request.
- mem_addr  out  PC_W  byte address, stable while mem_req=1.
- mem_rvalid  in  1  read data valid; at most one request outstanding.
- mem_rdata  in  8  read byte.
- mem_err  in  1  qualifies mem_rvalid; access fault.
- instr_valid  out  1  instruction bundle valid.
- instr_ready  in  1  decode accepts bundle.
- icode, ifun  out  4 each  opcode byte fields.
- rA, rB  out  4 each  register byte; 4'hF when the instruction has no register byte.
- valC  out  64  little-endian constant; 0 when unused.
- valP  out  PC_W  PC of the next sequential instruction.
- pc_out  out  PC_W  PC of this instruction.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  high in any state other than IDLE/HALTED.

Behaviour:
- Reset values: state IDLE; all outputs 0; rA/rB=4'hF; stat=1; pc register=0.
- States and transitions:
  - IDLE --start--> REQ.
  - REQ: issues the request for byte index k; mem_req=1, mem_addr=pc+k. --> WAIT.
  - WAIT: waits for mem_rvalid.
    - Byte 0 determines length L from icode: 0,1,9 -> 1; 2,6,A,B -> 2; 3,4,5 -> 10; 7,8 -> 9.
    - If k+1<L --> REQ; else --> HOLD.
  - HOLD: instr_valid=1; fields and outputs stay stable until instr_ready.
    - On handshake: pc<=valP and --> REQ, except stat!=AOK --> HALTED.
  - HALTED: idle until start.
- Byte assembly:
  - With a register byte: rA=byte1[7:4], rB=byte1[3:0], and valC comes from bytes 2..9.
  - Without a register byte: valC comes from bytes 1..8.
  - valC byte i lands in bits [8i+7:8i].
- valP = pc + L, computed modulo 2^PC_W.
- Best-case throughput: one byte per 2 cycles (REQ+WAIT), e.g. a 1-byte nop is delivered in HOLD 2 cycles after REQ.
- Halt (icode 0): stat=HLT, L=1, delivered normally, then HALTED.
- Invalid icode (>4'hB) or invalid ifun (OPq ifun>3, jXX/cmov ifun>6):
  - stat=INS; no further bytes are fetched; L=1.
  - Delivered, then HALTED.
- Address error: if pc+k >= IMEM_SIZE, or mem_err with mem_rvalid, then no request is issued (or the response is dropped). stat=ADR; the bundle is delivered with bytes fetched so far, then HALTED.
- Redirect:
  - In REQ/WAIT/HOLD: pc<=redirect_pc, k<=0, state --> REQ next cycle.
  - Partial or held instruction is discarded. An outstanding request's response is dropped via a one-bit "discard" flag.
  - Redirect in the same cycle as a HOLD handshake: the transfer completes, then fetch resumes at redirect_pc (not valP).
  - Redirect in IDLE/HALTED is ignored.
- start while busy is ignored.
- Reset mid-operation: immediate return to reset values; any outstanding response after reset is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, two extra outputs:
  - instr_count[31:0]: increments per accepted bundle.
  - stall_count[31:0]: increments per HOLD cycle with instr_ready=0.
  - Both clear on reset and on start; both wrap at 2^32.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ), stat codes (S_AOK, S_HLT, S_ADR, S_INS), RNONE=4'hF.
  - State enum.
  - instr_len(icode) function returning 1/2/9/10 and a valid-icode flag.
- Sub-module fetch_len_decode (combinational: icode/ifun -> L, has_regids, has_valC, ins_err), instantiated once.

Test Plan:
- start_pc=0x100, memory holds 30 F3 08 07 06 05 04 03 02 01 (irmovq), instr_ready=1 -> icode=3, rA=F, rB=3, valC=0x0102030405060708, valP=0x10A, stat=1.
- Sequence 10 | 60 23 | 90, instr_ready low 3 cycles in HOLD -> three bundles with pc_out 0,1,3; fields stable during stall; valP=1,3,4.
- Byte 0x00 at 0x20 -> bundle stat=HLT, valP=0x21, then HALTED, mem_req stays 0, busy=0.
- Opcode byte 0xC0 -> stat=INS, only 1 request issued, then HALTED; IMEM_SIZE=16 with irmovq at 0x0C -> stat=ADR after 4 bytes, no request to address 0x10.
- redirect_valid with redirect_pc=0x40 while WAIT on byte 5 of 0x30 -> late response dropped, next mem_addr=0x40, no bundle for 0x30.
- Assert rst_n low while in WAIT -> outputs at reset values asynchronously; a mem_rvalid arriving after release does not change state.
